sw_reader: RTL and testbench
============================

// Module: sw_reader
// PURPOSE
//  Input-side counterpart of the LED output path: samples the raw board switches
//  (asynchronous to clk, mechanically bouncy) and presents clean values to the core.
//  - Synchronises and debounces each switch.
//  - Exposes the stable switch vector.
//  - Emits change events over a valid/ready handshake; events accumulate under backpressure.
// PARAMETERS
//  NSW        2   number of switches
//  DB_CYCLES  16  consecutive differing cycles required to accept a new level (>= 2)
//  CNT_W      $clog2(DB_CYCLES)  debounce counter width (derived, not overridden)
// PORTS
//  clk        in   1    single clock; all logic on posedge
//  rst        in   1    synchronous reset, active-low (0 = reset)
//  sw         in   NSW  raw switch levels, asynchronous
//  sw_stable  out  NSW  debounced switch levels
//  evt_valid  out  1    change event pending
//  evt_ready  in   1    consumer accepts event (fire = evt_valid & evt_ready)
//  evt_bits   out  NSW  mask of switches that changed since last fire
//  evt_value  out  NSW  sw_stable value at the latest accumulated change
//  evt_ovf    out  1    a bit already set in evt_bits changed again before fire
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - Sync flops, counters, sw_stable, evt_valid, evt_bits, evt_value and evt_ovf all go to 0.
//   - Any debounce in progress is discarded.
//  Synchroniser: 2 flops per bit (s1 <= sw, s2 <= s1); no logic between s1 and s2.
//  Debounce, per bit, each posedge:
//   - s2 == stable: cnt <= 0.
//   - s2 != stable, cnt == DB_CYCLES-1: stable <= s2, cnt <= 0.
//   - Otherwise: cnt <= cnt+1.
//  Latency: a level held on sw from before edge k appears on sw_stable after edge
//   k+DB_CYCLES+1, i.e. DB_CYCLES+2 edges total.
//  Glitches: a pulse held for at most DB_CYCLES-1 sampled cycles never reaches sw_stable.
//  Change mask: chg = bits whose stable flips at this edge.
//  Event register, per posedge, in priority order:
//   - chg==0 and fire: evt_valid <= 0, evt_bits <= 0, evt_ovf <= 0.
//   - chg!=0 and (fire or !evt_valid): evt_valid <= 1, evt_bits <= chg, evt_ovf <= 0,
//     evt_value <= new stable. A new change that coincides with a fire is never lost.
//   - chg!=0, evt_valid and !evt_ready: evt_bits <= evt_bits|chg, evt_value <= new stable,
//     evt_ovf <= evt_ovf | |(evt_bits & chg).
//   - Otherwise: hold.
//  evt_bits, evt_value and evt_ovf are held stable while evt_valid=1 and evt_ready=0,
//   except when accumulating.
//  evt_value is a don't-care while evt_valid=0, but it holds its last value.
//  Switches high when reset releases: after DB_CYCLES+2 edges a normal 0->1 change event
//   is reported.
//  All outputs are registered; nothing combinational from evt_ready to any output.
// STRUCTURE
//  Shared package sw_pkg:
//   - SW_NSW_DEFAULT and SW_DB_DEFAULT constants.
//   - Simulation override value SW_DB_SIM = 4.
//  Sub-module sw_debounce_bit, instantiated NSW times via generate:
//   - Contains the 2-flop sync, the counter and the stable flop.
//   - Outputs: stable, and a 1-cycle flip pulse.
//  The event register lives in sw_reader.
//  Elaboration check: fatal error if DB_CYCLES < 2 or NSW < 1.
// TESTING (NSW=2, DB_CYCLES=4, evt_ready=1 unless noted)
//  1. Reset release with sw=2'b11 held:
//     - Outputs stay 0 for 5 edges after release.
//     - At edge 6: sw_stable=2'b11, evt_valid=1, evt_bits=2'b11, evt_value=2'b11.
//     - Event clears 1 cycle later.
//  2. Glitch rejection: sw[0] 0->1 for 3 cycles, then back to 0 ->
//     - sw_stable stays 2'b00; evt_valid never asserts.
//     - Repeat the pulse with 4 cycles high -> exactly one event, evt_bits=2'b01.
//  3. Backpressure, evt_ready=0:
//     - sw[0] rises, then sw[1] rises 10 cycles later -> evt_bits=2'b11, evt_value=2'b11, evt_ovf=0.
//     - sw[0] then falls -> evt_value=2'b10, evt_ovf=1.
//     - evt_ready=1 -> single fire, then all event outputs clear.
//  4. Fire coincides with new change:
//     - Setup: event pending with evt_bits=2'b01.
//     - Stimulus: evt_ready=1 on the same edge sw_stable[1] flips.
//     - Next cycle: evt_valid=1, evt_bits=2'b10, evt_ovf=0.
//  5. Reset mid-debounce:
//     - Stimulus: rst=0 for 1 edge when cnt=2 on sw[0].
//     - After release: full DB_CYCLES+2 latency restarts; no event appears earlier.
//  6. Random bounce (2-50 cycle pulses) plus random evt_ready; scoreboard checks:
//     - Every stable flip appears in some fired evt_bits.
//     - evt_value equals sw_stable at the cycle of the last accumulated change.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the switch reader.
//  - Default switch count and debounce length, plus the short debounce length
//    used in simulation so tests stay fast.
//  - The event register's per-cycle action and the helper that selects it.
package sw_pkg;

  localparam int SW_NSW_DEFAULT = 2;
  localparam int SW_DB_DEFAULT  = 16;
  localparam int SW_DB_SIM      = 4;

  // What the event register does on a given edge.
  typedef enum logic [1:0] {
    EVT_HOLD,   // nothing new, not fired (or stalled with no change)
    EVT_CLEAR,  // fired and nothing new arrived
    EVT_LOAD,   // new change into an empty or just-fired slot
    EVT_ACCUM   // new change merged into a stalled pending event
  } evt_action_e;

  // Priority: clear-on-fire, then load, then accumulate. A change that lands on
  // the same edge as a fire takes the load path, so it is never dropped.
  function automatic evt_action_e evt_action(input logic chg_any,
                                             input logic fire,
                                             input logic valid);
    if (!chg_any && fire)          return EVT_CLEAR;
    else if (chg_any && (fire || !valid)) return EVT_LOAD;
    else if (chg_any)              return EVT_ACCUM;
    else                           return EVT_HOLD;
  endfunction

endpackage

// File: rtl/sw_reader_if.sv
// Change-event handshake between the switch reader and its consumer.
//  evt_valid  event pending (producer)
//  evt_ready  consumer accepts; fire = evt_valid & evt_ready
//  evt_bits   mask of switches that changed since the last fire
//  evt_value  debounced switch vector at the latest accumulated change
//  evt_ovf    some bit already in evt_bits changed again before the fire
interface sw_reader_if
  import sw_pkg::*;
#(
  parameter int NSW = SW_NSW_DEFAULT
);
  logic           evt_valid;
  logic           evt_ready;
  logic [NSW-1:0] evt_bits;
  logic [NSW-1:0] evt_value;
  logic           evt_ovf;

  modport master (
    output evt_valid, evt_bits, evt_value, evt_ovf,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_bits, evt_value, evt_ovf,
    output evt_ready
  );
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch: 2-flop synchroniser, debounce counter and stable level.
//  clk     clock, all logic on posedge
//  rst     synchronous reset, active-low
//  sw_i    raw switch level, asynchronous to clk
//  stable  debounced level (registered)
//  flip    high for the cycle in which stable is about to toggle; it is
//          decoded from flops so the parent can act on the same edge
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int DB_CYCLES = SW_DB_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic stable,
  output logic flip
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // NOTE: every variable gets its default first, so no path through the
  // if/else leaves one unassigned and no latch is inferred.
  always_comb begin
    s1_d     = sw_i;
    s2_d     = s1_q;   // plain wire between the two sync stages
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip     = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // DB_CYCLES consecutive differing samples: accept the new level.
      stable_d = s2_q;
      cnt_d    = '0;
      flip     = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/sw_reader.sv
// Switch reader: debounces NSW raw switches and reports changes as events.
//  clk        clock, all logic on posedge
//  rst        synchronous reset, active-low
//  sw         raw switch levels, asynchronous
//  sw_stable  debounced switch levels
//  evt        change-event handshake (master side); changes accumulate in
//             evt_bits while the consumer holds evt_ready low
// All outputs come straight from flops; evt_ready only steers next state.
module sw_reader
  import sw_pkg::*;
#(
  parameter int NSW       = SW_NSW_DEFAULT,
  parameter int DB_CYCLES = SW_DB_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NSW-1:0] sw,
  output logic [NSW-1:0] sw_stable,
  sw_reader_if.master    evt
);

  if (DB_CYCLES < 2 || NSW < 1) begin : g_param_check
    $fatal(1, "sw_reader: DB_CYCLES must be >= 2 and NSW must be >= 1");
  end

  logic [NSW-1:0] stable_w;
  logic [NSW-1:0] chg;

  for (genvar i = 0; i < NSW; i++) begin : g_bit
    sw_debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .sw_i   (sw[i]),
      .stable (stable_w[i]),
      .flip   (chg[i])
    );
  end

  assign sw_stable = stable_w;

  logic           evt_valid_q, evt_valid_d;
  logic [NSW-1:0] evt_bits_q,  evt_bits_d;
  logic [NSW-1:0] evt_value_q, evt_value_d;
  logic           evt_ovf_q,   evt_ovf_d;
  logic [NSW-1:0] new_stable;
  logic           fire;

  always_comb begin
    // Stable vector as it will be after this edge.
    new_stable  = stable_w ^ chg;
    fire        = evt_valid_q & evt.evt_ready;
    evt_valid_d = evt_valid_q;
    evt_bits_d  = evt_bits_q;
    evt_value_d = evt_value_q;
    evt_ovf_d   = evt_ovf_q;
    unique case (evt_action(|chg, fire, evt_valid_q))
      EVT_CLEAR: begin
        evt_valid_d = 1'b0;
        evt_bits_d  = '0;
        evt_ovf_d   = 1'b0;
      end
      EVT_LOAD: begin
        evt_valid_d = 1'b1;
        evt_bits_d  = chg;
        evt_value_d = new_stable;
        evt_ovf_d   = 1'b0;
      end
      EVT_ACCUM: begin
        evt_bits_d  = evt_bits_q | chg;
        evt_value_d = new_stable;
        // A bit changing twice before the consumer saw it loses a transition.
        evt_ovf_d   = evt_ovf_q | (|(evt_bits_q & chg));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_valid_q <= 1'b0;
      evt_bits_q  <= '0;
      evt_value_q <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_bits_q  <= evt_bits_d;
      evt_value_q <= evt_value_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_bits  = evt_bits_q;
  assign evt.evt_value = evt_value_q;
  assign evt.evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_sw_reader.sv
// Bench for sw_reader with NSW=2 and the short simulation debounce length.
// A reference model works from a history of sampled switch levels: a bit's
// stable level toggles once the last DB_CYCLES synchronised samples all
// disagree with it. Outputs are compared with the model on every falling edge,
// and directed sequences pin the model with hand-computed values.
module tb_sw_reader;
  import sw_pkg::*;

  localparam int NSW = 2;
  localparam int DB  = SW_DB_SIM;

  bit             clk;
  logic           rst;
  logic [NSW-1:0] sw;
  logic [NSW-1:0] sw_stable;

  sw_reader_if #(.NSW(NSW)) ev ();

  sw_reader #(
    .NSW       (NSW),
    .DB_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .sw_stable (sw_stable),
    .evt       (ev.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NSW-1:0] samp_q[$];      // sw level sampled at each edge, oldest first
  logic [NSW-1:0] m_stable = '0;
  logic           m_valid  = 1'b0;
  logic [NSW-1:0] m_bits   = '0;
  logic [NSW-1:0] m_value  = '0;
  logic           m_ovf    = 1'b0;
  logic [NSW-1:0] acc_flips    = '0;  // flips not yet handed over by a fire
  logic [NSW-1:0] fired_expect = '0;  // flips the most recent fire must cover
  logic           ready_at_edge = 1'b0;
  logic           rst_at_edge   = 1'b0;

  initial begin
    for (int i = 0; i < DB + 3; i++) samp_q.push_back('0);
  end

  always @(posedge clk) begin : model
    logic [NSW-1:0] chg;
    logic [NSW-1:0] new_st;
    logic           fire;
    logic           all_diff;
    int             n;
    ready_at_edge = ev.evt_ready;
    rst_at_edge   = rst;
    if (!rst) begin
      // Both sync stages are cleared: the sample in flight and this one read as 0.
      samp_q[samp_q.size()-1] = '0;
      samp_q.push_back('0);
      m_stable = '0; m_valid = 1'b0; m_bits = '0; m_value = '0; m_ovf = 1'b0;
      acc_flips = '0; fired_expect = '0;
    end else begin
      samp_q.push_back(sw);
      n   = samp_q.size();
      chg = '0;
      // The debouncer sees the level sampled two edges back.
      for (int b = 0; b < NSW; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (samp_q[n-3-j][b] == m_stable[b]) all_diff = 1'b0;
        chg[b] = all_diff;
      end
      new_st = m_stable ^ chg;
      fire   = m_valid && ev.evt_ready;
      if (chg == '0) begin
        if (fire) begin m_valid = 1'b0; m_bits = '0; m_ovf = 1'b0; end
      end else if (fire || !m_valid) begin
        m_valid = 1'b1; m_bits = chg; m_value = new_st; m_ovf = 1'b0;
      end else begin
        m_ovf   = m_ovf | (|(m_bits & chg));
        m_bits  = m_bits | chg;
        m_value = new_st;
      end
      if (fire) begin fired_expect = acc_flips; acc_flips = chg; end
      else acc_flips = acc_flips | chg;
      m_stable = new_st;
    end
    if (samp_q.size() > 64) void'(samp_q.pop_front());
  end

  // ---------------- per-cycle compare ----------------
  logic           prev_valid = 1'b0;
  logic [NSW-1:0] prev_bits  = '0;

  always @(negedge clk) begin
    check("sw_stable", 8'(sw_stable), 8'(m_stable));
    check("evt_valid", 8'(ev.evt_valid), 8'(m_valid));
    check("evt_bits",  8'(ev.evt_bits),  8'(m_bits));
    check("evt_value", 8'(ev.evt_value), 8'(m_value));
    check("evt_ovf",   8'(ev.evt_ovf),   8'(m_ovf));
    // Whatever the DUT fired must include every flip since the previous fire.
    if (rst_at_edge && prev_valid && ready_at_edge)
      check("fire_cover", 8'(prev_bits & fired_expect), 8'(fired_expect));
    prev_valid = ev.evt_valid;
    prev_bits  = ev.evt_bits;
  end

  // ---------------- stimulus ----------------
  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic           saw;
    int             cnt;
    int             hold [NSW];
    logic [NSW-1:0] swv;

    rst = 1'b0;
    sw  = 2'b11;
    ev.evt_ready = 1'b1;
    wait_neg(3);

    // 1. Reset release with both switches high.
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("rel_stable_low", 8'(sw_stable), 8'h0);
      check("rel_valid_low",  8'(ev.evt_valid), 8'h0);
    end
    @(negedge clk);
    check("rel_stable", 8'(sw_stable), 8'h3);
    check("rel_valid",  8'(ev.evt_valid), 8'h1);
    check("rel_bits",   8'(ev.evt_bits), 8'h3);
    check("rel_value",  8'(ev.evt_value), 8'h3);
    @(negedge clk);
    check("rel_clear_valid", 8'(ev.evt_valid), 8'h0);
    check("rel_clear_bits",  8'(ev.evt_bits), 8'h0);

    // 2. Glitch rejection.
    sw = 2'b00;
    wait_neg(12);
    check("settle_00", 8'(sw_stable), 8'h0);
    sw = 2'b01;
    wait_neg(3);
    sw = 2'b00;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ev.evt_valid || sw_stable != 2'b00) saw = 1'b1;
    end
    check("glitch_ignored", 8'(saw), 8'h0);
    sw = 2'b01;
    wait_neg(4);
    sw = 2'b00;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ev.evt_valid && ev.evt_bits == 2'b01 && ev.evt_value == 2'b01) cnt++;
    end
    check("pulse4_one_rise_evt", 8'(cnt), 8'h1);

    // 3. Backpressure accumulation and overflow.
    ev.evt_ready = 1'b0;
    sw = 2'b01;
    wait_neg(10);
    sw = 2'b11;
    wait_neg(10);
    check("bp_bits",  8'(ev.evt_bits), 8'h3);
    check("bp_value", 8'(ev.evt_value), 8'h3);
    check("bp_ovf0",  8'(ev.evt_ovf), 8'h0);
    sw = 2'b10;
    wait_neg(10);
    check("bp_value2", 8'(ev.evt_value), 8'h2);
    check("bp_ovf1",   8'(ev.evt_ovf), 8'h1);
    check("bp_valid",  8'(ev.evt_valid), 8'h1);
    ev.evt_ready = 1'b1;
    @(negedge clk);
    check("bp_fire_valid", 8'(ev.evt_valid), 8'h0);
    check("bp_fire_bits",  8'(ev.evt_bits), 8'h0);
    check("bp_fire_ovf",   8'(ev.evt_ovf), 8'h0);

    // 4. Fire on the same edge as a new flip.
    ev.evt_ready = 1'b0;
    sw = 2'b11;
    wait_neg(8);
    check("coinc_setup_bits", 8'(ev.evt_bits), 8'h1);
    sw = 2'b01;
    wait_neg(5);
    check("coinc_pre_stable", 8'(sw_stable), 8'h3);
    ev.evt_ready = 1'b1;
    @(negedge clk);
    check("coinc_valid", 8'(ev.evt_valid), 8'h1);
    check("coinc_bits",  8'(ev.evt_bits), 8'h2);
    check("coinc_ovf",   8'(ev.evt_ovf), 8'h0);
    check("coinc_value", 8'(ev.evt_value), 8'h1);

    // 5. Reset in the middle of a debounce.
    sw = 2'b00;
    wait_neg(12);
    sw = 2'b01;
    wait_neg(4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("mid_rst_stable_low", 8'(sw_stable), 8'h0);
      check("mid_rst_valid_low",  8'(ev.evt_valid), 8'h0);
    end
    @(negedge clk);
    check("mid_rst_stable", 8'(sw_stable), 8'h1);
    check("mid_rst_bits",   8'(ev.evt_bits), 8'h1);

    // 6. Random bounce with random backpressure.
    swv = sw;
    for (int b = 0; b < NSW; b++) hold[b] = $urandom_range(2, 50);
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NSW; b++) begin
        if (hold[b] == 0) begin
          swv[b]  = ~swv[b];
          hold[b] = $urandom_range(2, 50);
        end else begin
          hold[b]--;
        end
      end
      sw = swv;
      ev.evt_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
